// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and constants for the K&S RAM access arbiter.
package ram_access_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_WAIT_RD} arb_state_t;

  typedef enum logic {OWN_CORE, OWN_EXT} arb_owner_t;

  localparam int unsigned ARB_MAX_RD_LATENCY = 4;

  // Wide enough to hold ARB_MAX_RD_LATENCY in the read-wait counter
  localparam int unsigned ARB_CNT_W = $clog2(ARB_MAX_RD_LATENCY + 1);

endpackage

// File: rtl/arb_rr2_pick.sv
// Combinational two-way round-robin picker with optional fixed external priority.
module arb_rr2_pick
  import ram_access_arbiter_pkg::*;
(
  input  logic req_core_i,
  input  logic req_ext_i,
  input  logic last_owner_i,
  input  logic ext_prio_i,
  output logic winner_o,
  output logic valid_o
);

  // On a tie the requester that did not own the RAM last wins, unless ext has priority
  always_comb begin
    valid_o  = req_core_i | req_ext_i;
    winner_o = OWN_CORE;
    if (req_core_i && req_ext_i) begin
      winner_o = (ext_prio_i || (last_owner_i == OWN_CORE)) ? OWN_EXT : OWN_CORE;
    end else if (req_ext_i) begin
      winner_o = OWN_EXT;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates the single program/data RAM port between the core and the loader/debug port.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  input  logic              core_halted_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  localparam logic [ARB_CNT_W-1:0] RdLatCnt = ARB_CNT_W'(RD_LATENCY);
  localparam logic [ARB_CNT_W-1:0] CntOne   = ARB_CNT_W'(1);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  arb_owner_t          last_owner_q, last_owner_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                pick_ext;
  logic                pick_valid;
  logic                win;

  arb_rr2_pick u_pick (
    .req_core_i   (core_req_i),
    .req_ext_i    (ext_req_i),
    .last_owner_i (last_owner_q),
    .ext_prio_i   (core_halted_i),
    .winner_o     (pick_ext),
    .valid_o      (pick_valid)
  );

  assign win = (state_q == ARB_IDLE) && pick_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one ACCESS cycle, then either back to IDLE or wait out the read latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:    if (pick_valid) state_d = ARB_ACCESS;
      ARB_ACCESS:  state_d = ram_we_q ? ARB_IDLE : ARB_WAIT_RD;
      ARB_WAIT_RD: if (cnt_q == CntOne) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Transaction capture, round-robin history and read-latency counter
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    cnt_d        = cnt_q;
    if (win) begin
      owner_d     = arb_owner_t'(pick_ext);
      ram_we_d    = pick_ext ? ext_we_i    : core_we_i;
      ram_addr_d  = pick_ext ? ext_addr_i  : core_addr_i;
      ram_wdata_d = pick_ext ? ext_wdata_i : core_wdata_i;
    end
    if (state_q == ARB_ACCESS) begin
      last_owner_d = owner_q;
      cnt_d        = RdLatCnt;
    end
    if (state_q == ARB_WAIT_RD) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Datapath registers; last_owner resets to EXT so the core wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_EXT;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cnt_q        <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs decoded from state and owner; read data passes straight through
  always_comb begin
    core_gnt_o    = (state_q == ARB_ACCESS) && (owner_q == OWN_CORE);
    ext_gnt_o     = (state_q == ARB_ACCESS) && (owner_q == OWN_EXT);
    core_rvalid_o = (state_q == ARB_WAIT_RD) && (cnt_q == CntOne) && (owner_q == OWN_CORE);
    ext_rvalid_o  = (state_q == ARB_WAIT_RD) && (cnt_q == CntOne) && (owner_q == OWN_EXT);
    core_rdata_o  = ram_rdata_i;
    ext_rdata_o   = ram_rdata_i;
    ram_we_o      = ram_we_q;
    ram_addr_o    = ram_addr_q;
    ram_wdata_o   = ram_wdata_q;
    busy_o        = (state_q != ARB_IDLE);
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: three instances with read latency 1, 3 and 4.
module tb_ram_access_arbiter;

  typedef struct packed {
    logic        ext;
    logic [15:0] data;
  } sb_t;

  logic        clk;
  logic        rst_n       [3];
  logic        core_req    [3];
  logic        core_we     [3];
  logic [4:0]  core_addr   [3];
  logic [15:0] core_wdata  [3];
  logic        core_gnt    [3];
  logic        core_rvalid [3];
  logic [15:0] core_rdata  [3];
  logic        ext_req     [3];
  logic        ext_we      [3];
  logic [4:0]  ext_addr    [3];
  logic [15:0] ext_wdata   [3];
  logic        ext_gnt     [3];
  logic        ext_rvalid  [3];
  logic [15:0] ext_rdata   [3];
  logic        core_halted [3];
  logic [4:0]  ram_addr    [3];
  logic        ram_we      [3];
  logic [15:0] ram_wdata   [3];
  logic        busy        [3];

  logic [15:0] shadow [3][32];
  sb_t         sb_q[$];
  int          n_vec;
  int          n_fail;
  int          cyc;

  function automatic logic [15:0] init_val(input logic [4:0] a);
    return (a == 5'h03) ? 16'hBEEF : {3'b101, a, 3'b010, a};
  endfunction

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [15:0] mem  [32];
    logic [15:0] pipe [4];

    initial for (int i = 0; i < 32; i++) mem[i] = init_val(5'(i));

    // RAM model: write on the ACCESS edge, read data delayed Lat cycles from the address
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= mem[ram_addr[g]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    ram_access_arbiter #(
      .ADDR_W     (5),
      .DATA_W     (16),
      .RD_LATENCY (Lat)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .core_req_i    (core_req[g]),
      .core_we_i     (core_we[g]),
      .core_addr_i   (core_addr[g]),
      .core_wdata_i  (core_wdata[g]),
      .core_gnt_o    (core_gnt[g]),
      .core_rvalid_o (core_rvalid[g]),
      .core_rdata_o  (core_rdata[g]),
      .ext_req_i     (ext_req[g]),
      .ext_we_i      (ext_we[g]),
      .ext_addr_i    (ext_addr[g]),
      .ext_wdata_i   (ext_wdata[g]),
      .ext_gnt_o     (ext_gnt[g]),
      .ext_rvalid_o  (ext_rvalid[g]),
      .ext_rdata_o   (ext_rdata[g]),
      .core_halted_i (core_halted[g]),
      .ram_addr_o    (ram_addr[g]),
      .ram_we_o      (ram_we[g]),
      .ram_wdata_o   (ram_wdata[g]),
      .ram_rdata_i   (pipe[Lat-1]),
      .busy_o        (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic ext, input logic [15:0] d);
    sb_t e;
    e.ext  = ext;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Advance one cycle, sample at the falling edge, retire any read response
  task automatic step(input int idx, output logic cg, output logic eg,
                      output logic cr, output logic er);
    sb_t e;
    @(negedge clk);
    cyc++;
    cg = core_gnt[idx];
    eg = ext_gnt[idx];
    cr = core_rvalid[idx];
    er = ext_rvalid[idx];
    if (cr || er) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rvalid", 32'({cr, er}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_rvalid_owner", 32'({cr, er}), e.ext ? 32'd1 : 32'd2);
        check("sb_rdata", 32'(er ? ext_rdata[idx] : core_rdata[idx]), 32'(e.data));
      end
    end
  endtask

  task automatic set_req(input int idx, input logic is_ext, input logic req, input logic we,
                         input logic [4:0] addr, input logic [15:0] wdata);
    if (is_ext) begin
      ext_req[idx] = req; ext_we[idx] = we; ext_addr[idx] = addr; ext_wdata[idx] = wdata;
    end else begin
      core_req[idx] = req; core_we[idx] = we; core_addr[idx] = addr; core_wdata[idx] = wdata;
    end
  endtask

  task automatic check_zero(input int idx, input string tag);
    check({tag, "_ctl"}, 32'({core_gnt[idx], ext_gnt[idx], core_rvalid[idx], ext_rvalid[idx],
                              ram_we[idx], busy[idx]}), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr[idx]), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata[idx]), 32'd0);
  endtask

  task automatic rst_inst(input int idx);
    @(negedge clk);
    rst_n[idx] = 1'b0;
    @(negedge clk);
    check_zero(idx, "rst");
    rst_n[idx] = 1'b1;
  endtask

  // One isolated access on an idle arbiter with full timing checks
  task automatic single(input int idx, input logic is_ext, input logic we,
                        input logic [4:0] addr, input logic [15:0] wdata);
    logic cg, eg, cr, er;
    int   n;
    @(negedge clk);
    set_req(idx, is_ext, 1'b1, we, addr, wdata);
    n = 0;
    do begin
      step(idx, cg, eg, cr, er);
      n++;
    end while (!(is_ext ? eg : cg) && n < 20);
    check("single_gnt_latency", 32'(n), 32'd1);
    set_req(idx, is_ext, 1'b0, 1'b0, 5'h00, 16'h0000);
    check("single_other_gnt", 32'(is_ext ? cg : eg), 32'd0);
    check("single_ram_addr", 32'(ram_addr[idx]), 32'(addr));
    check("single_ram_we", 32'(ram_we[idx]), 32'(we));
    check("single_busy_access", 32'(busy[idx]), 32'd1);
    if (we) begin
      check("single_ram_wdata", 32'(ram_wdata[idx]), 32'(wdata));
      shadow[idx][addr] = wdata;
      step(idx, cg, eg, cr, er);
      check("single_we_pulse", 32'(ram_we[idx]), 32'd0);
    end else begin
      push_exp(is_ext, shadow[idx][addr]);
      n = 0;
      do begin
        step(idx, cg, eg, cr, er);
        n++;
        if (!(cr || er)) check("single_busy_wait", 32'(busy[idx]), 32'd1);
      end while (!(cr || er) && n < 20);
      check("single_rvalid_latency", 32'(n), 32'(lat_of(idx)));
      step(idx, cg, eg, cr, er);
    end
    check("single_busy_after", 32'(busy[idx]), 32'd0);
  endtask

  initial begin
    logic cg, eg, cr, er;
    int   ngnt, n_e, last_g, raise_at, ext_at;
    logic core_done, ext_done;

    n_vec = 0;
    n_fail = 0;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      core_halted[i] = 1'b0;
      set_req(i, 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
      set_req(i, 1'b1, 1'b0, 1'b0, 5'h00, 16'h0000);
      for (int a = 0; a < 32; a++) shadow[i][a] = init_val(5'(a));
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "init_rst");
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Basic read, ext write, read-back of the written word
    single(0, 1'b0, 1'b0, 5'h03, 16'h0000);
    single(0, 1'b1, 1'b1, 5'h1F, 16'h1234);
    single(0, 1'b0, 1'b0, 5'h1F, 16'h0000);

    // Both requesting, not halted: strict alternation starting with core
    rst_inst(0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, 1'b0, 5'h05, 16'h0000);
    set_req(0, 1'b1, 1'b1, 1'b0, 5'h0A, 16'h0000);
    ngnt = 0;
    for (int c = 0; c < 60 && !(ngnt == 4 && sb_q.size() == 0); c++) begin
      step(0, cg, eg, cr, er);
      if (cg || eg) begin
        check("rr_dual_gnt", 32'(cg & eg), 32'd0);
        check("rr_owner", 32'(eg), 32'(ngnt % 2));
        push_exp(eg, shadow[0][eg ? 5'h0A : 5'h05]);
        ngnt++;
        if (ngnt == 4) begin
          core_req[0] = 1'b0;
          ext_req[0] = 1'b0;
        end
      end
    end
    check("rr_grant_count", 32'(ngnt), 32'd4);

    // Halted core: ext holds the RAM until it stops requesting
    core_halted[0] = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, 1'b0, 5'h06, 16'h0000);
    set_req(0, 1'b1, 1'b1, 1'b0, 5'h08, 16'h0000);
    n_e = 0;
    core_done = 1'b0;
    for (int c = 0; c < 80 && !(core_done && sb_q.size() == 0); c++) begin
      step(0, cg, eg, cr, er);
      if (eg) begin
        push_exp(1'b1, shadow[0][5'h08]);
        n_e++;
        if (n_e == 4) ext_req[0] = 1'b0;
      end
      if (cg) begin
        check("halt_core_gnt_early", 32'(n_e), 32'd4);
        push_exp(1'b0, shadow[0][5'h06]);
        core_req[0] = 1'b0;
        core_done = 1'b1;
      end
    end
    check("halt_ext_count", 32'(n_e), 32'd4);
    check("halt_core_granted", 32'(core_done), 32'd1);
    core_halted[0] = 1'b0;

    // Latency 3: reset lands in the first WAIT_RD cycle, the read must vanish
    single(1, 1'b0, 1'b0, 5'h02, 16'h0000);
    @(negedge clk);
    set_req(1, 1'b0, 1'b1, 1'b0, 5'h07, 16'h0000);
    step(1, cg, eg, cr, er);
    check("abort_gnt", 32'(cg), 32'd1);
    set_req(1, 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    step(1, cg, eg, cr, er);
    check("abort_busy_wait", 32'(busy[1]), 32'd1);
    rst_n[1] = 1'b0;
    step(1, cg, eg, cr, er);
    check_zero(1, "abort_rst");
    rst_n[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1, cg, eg, cr, er);
      check("abort_quiet", 32'({cg, eg, cr, er, busy[1]}), 32'd0);
    end

    // Latency 4: back-to-back core reads, ext arrives mid-read
    rst_inst(2);
    @(negedge clk);
    set_req(2, 1'b0, 1'b1, 1'b0, 5'h11, 16'h0000);
    ngnt = 0;
    last_g = 0;
    raise_at = -1;
    ext_at = -1;
    ext_done = 1'b0;
    for (int c = 0; c < 80 && !(ext_done && sb_q.size() == 0); c++) begin
      step(2, cg, eg, cr, er);
      if (cr) check("l4_rvalid_spacing", 32'(cyc - last_g), 32'd4);
      if (cg) begin
        check("l4_ram_addr", 32'(ram_addr[2]), 32'(core_addr[2]));
        push_exp(1'b0, shadow[2][core_addr[2]]);
        if (ngnt > 0) check("l4_gnt_spacing", 32'(cyc - last_g), 32'd6);
        last_g = cyc;
        ngnt++;
        if (ngnt == 1) core_addr[2] = 5'h12;
        if (ngnt == 2) begin
          core_req[2] = 1'b0;
          raise_at = cyc + 2;
        end
      end
      if (cyc == raise_at) begin
        set_req(2, 1'b1, 1'b1, 1'b0, 5'h13, 16'h0000);
        ext_at = last_g + 6;
      end
      if (eg) begin
        check("l4_ext_gnt_time", 32'(cyc), 32'(ext_at));
        push_exp(1'b1, shadow[2][5'h13]);
        ext_req[2] = 1'b0;
        ext_done = 1'b1;
      end
    end
    check("l4_core_grants", 32'(ngnt), 32'd2);
    check("l4_ext_granted", 32'(ext_done), 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
